// File: rtl/lea_pkg.sv
// Shared LEA-128 constants, sequencer/mode types and word helpers.
// Blocks are byte strings (byte 0 in the MSBs); cipher words are little-endian over those bytes.
package lea_pkg;

  localparam int unsigned LEA_NR = 24;
  localparam int unsigned LEA_DW = 128;
  localparam int unsigned LEA_KW = 192;
  localparam int unsigned LEA_AW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lea_seq_state_t;

  typedef enum logic {
    LEA_ENC = 1'b0,
    LEA_DEC = 1'b1
  } lea_mode_t;

  // Full byte reversal: turns the byte-string block into {X3,X2,X1,X0} with X0 in [31:0].
  // It is its own inverse, so the same call packs words back into a block.
  function automatic logic [LEA_DW-1:0] byte_rev128(input logic [LEA_DW-1:0] b);
    logic [LEA_DW-1:0] r;
    for (int p = 0; p < 16; p++) begin
      r[8*p +: 8] = b[8*(15-p) +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] rol32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

endpackage

// File: rtl/LEA_Decrypt.sv
// One LEA decryption round: exact inverse of LEA_Encrypt under the same round key.
module LEA_Decrypt
  import lea_pkg::*;
(
  input  logic [LEA_DW-1:0] blk,
  input  logic [LEA_KW-1:0] rk,
  output logic [LEA_DW-1:0] res
);

  logic [LEA_DW-1:0] x;
  logic [31:0]       y0, y1, y2, y3;

  always_comb begin
    x   = byte_rev128(blk);
    y0  = x[127:96];
    y1  = (ror32(x[31:0], 9)  - (y0 ^ rk[31:0]))    ^ rk[63:32];
    y2  = (rol32(x[63:32], 5) - (y1 ^ rk[95:64]))   ^ rk[127:96];
    y3  = (rol32(x[95:64], 3) - (y2 ^ rk[159:128])) ^ rk[191:160];
    res = byte_rev128({y3, y2, y1, y0});
  end

endmodule

// File: rtl/LEA_Encrypt.sv
// One LEA encryption round. Round key word k sits at rk[32*k +: 32].
module LEA_Encrypt
  import lea_pkg::*;
(
  input  logic [LEA_DW-1:0] blk,
  input  logic [LEA_KW-1:0] rk,
  output logic [LEA_DW-1:0] res
);

  logic [LEA_DW-1:0] x;
  logic [31:0]       y0, y1, y2, y3;

  always_comb begin
    x   = byte_rev128(blk);
    y0  = rol32((x[31:0]  ^ rk[31:0])    + (x[63:32]  ^ rk[63:32]),   9);
    y1  = ror32((x[63:32] ^ rk[95:64])   + (x[95:64]  ^ rk[127:96]),  5);
    y2  = ror32((x[95:64] ^ rk[159:128]) + (x[127:96] ^ rk[191:160]), 3);
    y3  = x[31:0];
    res = byte_rev128({y3, y2, y1, y0});
  end

endmodule

// File: rtl/lea_round_mux.sv
// Combinational single-round datapath: encrypt and decrypt rounds, selected by mode.
module lea_round_mux
  import lea_pkg::*;
(
  input  logic [LEA_DW-1:0] st,
  input  logic [LEA_KW-1:0] rk,
  input  lea_mode_t         mode,
  output logic [LEA_DW-1:0] res
);

  logic [LEA_DW-1:0] enc_res;
  logic [LEA_DW-1:0] dec_res;

  LEA_Encrypt u_enc (
    .blk (st),
    .rk  (rk),
    .res (enc_res)
  );

  LEA_Decrypt u_dec (
    .blk (st),
    .rk  (rk),
    .res (dec_res)
  );

  assign res = (mode == LEA_DEC) ? dec_res : enc_res;

endmodule

// File: rtl/lea_round_sequencer.sv
// Iterative LEA-128 round sequencer: one round per cycle, keys fetched from an external store.
// Optional macro LEA_ABORT_EN adds an abort input that drops the block in flight.
module lea_round_sequencer
  import lea_pkg::*;
#(
  parameter int unsigned NR = LEA_NR,
  parameter int unsigned DW = LEA_DW,
  parameter int unsigned KW = LEA_KW,
  parameter int unsigned AW = LEA_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_mode,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] rk_addr,
  input  logic [KW-1:0] rk_data,
  output logic          busy
`ifdef LEA_ABORT_EN
  ,
  input  logic          abort
`endif
);

  localparam logic [1:0]    StIdle  = IDLE;
  localparam logic [1:0]    StRun   = RUN;
  localparam logic [1:0]    StDone  = DONE;
  localparam logic [AW-1:0] LastRnd = AW'(NR - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] rnd_q, rnd_d;
  logic [DW-1:0] st_reg, st_d;
  lea_mode_t     mode_q, mode_d;
  logic [DW-1:0] round_res;

  lea_round_mux u_round (
    .st   (st_reg),
    .rk   (rk_data),
    .mode (mode_q),
    .res  (round_res)
  );

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_reg;
    mode_d  = mode_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          st_d    = in_data;
          mode_d  = lea_mode_t'(in_mode);
          rnd_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        st_d  = round_res;
        rnd_d = rnd_q + 1'b1;
        if (rnd_q == LastRnd) begin
          rnd_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef LEA_ABORT_EN
    // Abort wins over out_ready, so a result sitting in DONE is discarded.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      rnd_d   = '0;
      st_d    = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rnd_q   <= '0;
      st_reg  <= '0;
      mode_q  <= LEA_ENC;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_reg  <= st_d;
      mode_q  <= mode_d;
    end
  end

  // Decrypt walks the schedule backwards; rnd never exceeds NR-1, so no underflow.
  always_comb begin
    rk_addr = '0;
    if (state_q == StRun) begin
      rk_addr = (mode_q == LEA_DEC) ? (LastRnd - rnd_q) : rnd_q;
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign out_data  = (state_q == StDone) ? st_reg : '0;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_lea_round_sequencer.sv
// Directed bench for lea_round_sequencer: LEA-128 KATs, backpressure, back-to-back, reset.
// Builds the key schedule and a reference encryptor locally; results go through a scoreboard.
module tb_lea_round_sequencer;

  localparam logic [127:0] KEY = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] PT  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT  = 128'h9fc84e3528c6c6185532c7a704648bfd;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [4:0]   rk_addr;
  logic [191:0] rk_data;
  logic         busy;
  logic         abort = 1'b0;

  logic [191:0] rk_mem [32];
  assign rk_data = rk_mem[rk_addr];

  lea_round_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .rk_addr   (rk_addr),
    .rk_data   (rk_data),
    .busy      (busy)
`ifdef LEA_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_acc  = 0;
  int n_out  = 0;
  int out_hs_edge = 0;
  logic [127:0] cur_exp;
  logic [127:0] exp_q [$];
  int           acc_edges [$];
  logic [4:0]   rk_log [$];
  logic         prev_valid = 1'b0;
  logic [127:0] prev_data  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    int m;
    m = n % 32;
    if (m == 0) return x;
    return (x << m) | (x >> (32 - m));
  endfunction

  function automatic logic [127:0] brev(input logic [127:0] b);
    logic [127:0] r;
    for (int p = 0; p < 16; p++) r[8*p +: 8] = b[8*(15-p) +: 8];
    return r;
  endfunction

  // Reference LEA-128 encryption written straight from the cipher definition.
  function automatic logic [127:0] lea_enc(input logic [127:0] p);
    logic [31:0] x [4];
    logic [31:0] k [6];
    logic [31:0] n0, n1, n2;
    logic [127:0] w;
    w = brev(p);
    for (int i = 0; i < 4; i++) x[i] = w[32*i +: 32];
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < 6; i++) k[i] = rk_mem[r][32*i +: 32];
      n0 = rol((x[0] ^ k[0]) + (x[1] ^ k[1]), 9);
      n1 = rol((x[1] ^ k[2]) + (x[2] ^ k[3]), 27);
      n2 = rol((x[2] ^ k[4]) + (x[3] ^ k[5]), 29);
      x[3] = x[0];
      x[0] = n0;
      x[1] = n1;
      x[2] = n2;
    end
    return brev({x[3], x[2], x[1], x[0]});
  endfunction

  task automatic build_keys();
    logic [31:0] delta [4];
    logic [31:0] t [4];
    logic [127:0] w;
    delta[0] = 32'hc3efe9db;
    delta[1] = 32'h44626b02;
    delta[2] = 32'h79e27c8a;
    delta[3] = 32'h78df30ec;
    w = brev(KEY);
    for (int i = 0; i < 4; i++) t[i] = w[32*i +: 32];
    for (int i = 0; i < 32; i++) rk_mem[i] = '0;
    for (int i = 0; i < 24; i++) begin
      t[0] = rol(t[0] + rol(delta[i%4], i), 1);
      t[1] = rol(t[1] + rol(delta[i%4], i + 1), 3);
      t[2] = rol(t[2] + rol(delta[i%4], i + 2), 6);
      t[3] = rol(t[3] + rol(delta[i%4], i + 3), 11);
      rk_mem[i] = {t[1], t[3], t[1], t[2], t[1], t[0]};
    end
  endtask

  // Monitor: scoreboard push on accept, pop on result handshake, plus per-cycle invariants.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        acc_edges.push_back(cyc + 1);
        n_acc++;
      end
      if (busy && !out_valid) rk_log.push_back(rk_addr);
      if (busy) check("in_ready_busy", 128'(in_ready), 128'(0));
      if (out_valid && !prev_valid) check("latency", 128'(cyc - acc_edges[$]), 128'(24));
      if (out_valid && prev_valid) check("hold_data", out_data, prev_data);
      if (out_valid && out_ready && !abort) begin
        if (exp_q.size() == 0) check("unexpected_output", 128'(exp_q.size()), 128'(1));
        else check("out_data", out_data, exp_q.pop_front());
        out_hs_edge = cyc + 1;
        n_out++;
      end
    end
    prev_valid = out_valid;
    prev_data  = out_data;
  end

  task automatic wait_acc(input int target, input int budget);
    int t = 0;
    while (n_acc < target && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("accept_timeout", 128'(n_acc), 128'(target));
  endtask

  task automatic wait_out(input int target, input int budget);
    int t = 0;
    while (n_out < target && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("output_timeout", 128'(n_out), 128'(target));
  endtask

  task automatic drive(input logic mode, input logic [127:0] data, input logic [127:0] exp);
    in_mode  = mode;
    in_data  = data;
    cur_exp  = exp;
    in_valid = 1'b1;
  endtask

  initial begin
    logic [127:0] blk_d [4];
    logic         blk_m [4];
    logic [127:0] blk_e [4];
    logic [127:0] r1, r2;
    int base_acc, base_out, t;

    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
    cur_exp = '0;
    build_keys();
    r1 = {$urandom, $urandom, $urandom, $urandom};
    r2 = {$urandom, $urandom, $urandom, $urandom};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_rk_addr", 128'(rk_addr), 128'(0));
    check("rst_out_data", out_data, 128'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 128'(in_ready), 128'(1));

    // Encrypt KAT under 10 cycles of backpressure; decrypt KAT offered meanwhile
    @(posedge clk); #1;
    drive(1'b0, PT, CT);
    wait_acc(1, 10);
    drive(1'b1, CT, PT);
    t = 0;
    while (!out_valid && t < 40) begin @(posedge clk); #1; t++; end
    check("enc_done_seen", 128'(out_valid), 128'(1));
    repeat (10) @(posedge clk);
    #1;
    check("bp_no_accept", 128'(n_acc), 128'(1));
    check("bp_no_output", 128'(n_out), 128'(0));
    out_ready = 1'b1;
    rk_log.delete();
    wait_acc(2, 10);
    in_valid = 1'b0;
    check("accept_after_ready", 128'(acc_edges[1]), 128'(out_hs_edge + 1));
    wait_out(2, 40);
    check("rk_log_len", 128'(rk_log.size()), 128'(24));
    for (int i = 0; i < rk_log.size() && i < 24; i++)
      check("dec_rk_addr", 128'(rk_log[i]), 128'(23 - i));

    // Back-to-back: in_valid and out_ready held high
    blk_d[0] = PT;          blk_m[0] = 1'b0; blk_e[0] = CT;
    blk_d[1] = CT;          blk_m[1] = 1'b1; blk_e[1] = PT;
    blk_d[2] = r1;          blk_m[2] = 1'b0; blk_e[2] = lea_enc(r1);
    blk_d[3] = lea_enc(r1); blk_m[3] = 1'b1; blk_e[3] = r1;
    base_acc = n_acc;
    base_out = n_out;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      drive(blk_m[k], blk_d[k], blk_e[k]);
      wait_acc(base_acc + k + 1, 40);
    end
    in_valid = 1'b0;
    wait_out(base_out + 4, 60);
    for (int k = 0; k < 3; k++)
      check("b2b_spacing", 128'(acc_edges[base_acc + k + 1] - acc_edges[base_acc + k]), 128'(26));

    // Reset at round 12, then a normal block
    drive(1'b0, r2, lea_enc(r2));
    wait_acc(n_acc + 1, 10);
    in_valid = 1'b0;
    base_out = n_out;
    repeat (12) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_in_ready", 128'(in_ready), 128'(1));
    check("mid_rst_rk_addr", 128'(rk_addr), 128'(0));
    @(posedge clk); #1;
    drive(1'b0, PT, CT);
    wait_acc(n_acc + 1, 10);
    in_valid = 1'b0;
    wait_out(base_out + 1, 40);

`ifdef LEA_ABORT_EN
    // Abort at round 5, then abort in DONE together with out_ready
    base_out = n_out;
    drive(1'b0, r1, lea_enc(r1));
    wait_acc(n_acc + 1, 10);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_out_valid", 128'(out_valid), 128'(0));
    out_ready = 1'b0;
    @(posedge clk); #1;
    drive(1'b0, PT, CT);
    wait_acc(n_acc + 1, 10);
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 40) begin @(posedge clk); #1; t++; end
    check("abort_done_seen", 128'(out_valid), 128'(1));
    abort = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_done_busy", 128'(busy), 128'(0));
    check("abort_done_valid", 128'(out_valid), 128'(0));
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_output", 128'(n_out), 128'(base_out));
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, required finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
